// File: rtl/frost32_mem_responder_pkg.sv
// Shared encodings and byte-lane helpers for the Frost32 memory responder.
package frost32_mem_responder_pkg;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  typedef enum logic [1:0] {
    Dias32  = 2'd0,
    Dias16  = 2'd1,
    Dias8   = 2'd2,
    DiasBad = 2'd3
  } DataInoutAccessSize;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic misaligned(DataInoutAccessSize size, logic [1:0] addr_lo);
    logic bad;
    case (size)
      Dias32:  bad = (addr_lo != 2'd0);
      Dias16:  bad = addr_lo[0];
      Dias8:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_enables(DataInoutAccessSize size, logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      Dias32:  be = 4'b1111;
      Dias16:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      Dias8:   be = 4'b0001 << addr_lo;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate narrow data across all lanes so the byte enables alone pick the target.
  function automatic logic [31:0] align_wdata(DataInoutAccessSize size, logic [31:0] data);
    logic [31:0] w;
    case (size)
      Dias16:  w = {2{data[15:0]}};
      Dias8:   w = {4{data[7:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract_rdata(DataInoutAccessSize size, logic [1:0] addr_lo,
                                                logic [31:0] word);
    logic [31:0] r;
    case (size)
      Dias32:  r = word;
      Dias16:  r = addr_lo[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      Dias8: begin
        case (addr_lo)
          2'd0:    r = {24'h0, word[7:0]};
          2'd1:    r = {24'h0, word[15:8]};
          2'd2:    r = {24'h0, word[23:16]};
          default: r = {24'h0, word[31:24]};
        endcase
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/frost32_mem_responder_if.sv
// CPU data-access bus between the Frost32 core (master) and its memory responder (slave).
interface frost32_mem_responder_if;
  logic        in_req_mem_access;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_access_type;
  logic [1:0]  in_access_size;
  logic [31:0] out_data;
  logic        out_busy;
  logic        out_ack;
  logic        out_err;

  modport master (
    output in_req_mem_access, in_addr, in_data, in_access_type, in_access_size,
    input  out_data, out_busy, out_ack, out_err
  );

  modport slave (
    input  in_req_mem_access, in_addr, in_data, in_access_type, in_access_size,
    output out_data, out_busy, out_ack, out_err
  );
endinterface

// File: rtl/frost32_byte_lane_ram.sv
// Word RAM with per-byte write enables, synchronous write and combinational read.
module frost32_byte_lane_ram #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/frost32_mem_responder.sv
// Memory-side responder for the Frost32 data port: one request at a time, acked LATENCY
// cycles after acceptance; requests are ignored while busy.
module frost32_mem_responder
  import frost32_mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY         = 2
) (
  input logic                  clk,
  input logic                  rst,
  frost32_mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        type_q, type_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ram_rdata;
  logic        err_cur;
  logic        ram_we;

  function automatic logic access_err(logic [31:0] addr, logic [1:0] size);
    return misaligned(DataInoutAccessSize'(size), addr[1:0]) || ((addr >> (AW + 2)) != 32'd0);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    type_d  = type_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (bus.in_req_mem_access) begin
          addr_d = bus.in_addr;
          data_d = bus.in_data;
          type_d = bus.in_access_type;
          size_d = bus.in_access_size;
          if (LATENCY == 1) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - CW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Read data is captured on entry to StDone so it is visible during the ack cycle.
    if (state_d == StDone && state_q != StDone) begin
      if (access_err(addr_d, size_d)) begin
        rdata_d = 32'h0;
      end else if (type_d == DiatRead) begin
        rdata_d = extract_rdata(DataInoutAccessSize'(size_d), addr_d[1:0], ram_rdata);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      type_q  <= 1'b0;
      size_q  <= 2'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      type_q  <= type_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  assign err_cur = access_err(addr_q, size_q);
  assign ram_we  = (state_q == StDone) && (type_q == DiatWrite) && !err_cur;

  frost32_byte_lane_ram #(.DEPTH(MEM_DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (lane_enables(DataInoutAccessSize'(size_q), addr_q[1:0])),
    .waddr_i (addr_q[AW+1:2]),
    .wdata_i (align_wdata(DataInoutAccessSize'(size_q), data_q)),
    .raddr_i (addr_d[AW+1:2]),
    .rdata_o (ram_rdata)
  );

  assign bus.out_ack  = (state_q == StDone);
  assign bus.out_busy = (state_q != StIdle);
  assign bus.out_err  = (state_q == StDone) && err_cur;
  assign bus.out_data = rdata_q;
endmodule

// File: doc/frost32_mem_responder.md
Name: frost32_mem_responder

Overview:
Memory-side responder for the Frost32 CPU data-access port. It accepts a CPU request (address, write data, read/write, access size) and performs the access on an internal word-organised RAM with per-byte lanes. It returns read data, or completes the write, after a configurable latency, signalling completion with an ack pulse. It sits between the CPU's memory-access outputs and its data input, and stands in for the memory system during CPU bring-up and simulation.

Parameters:
- MEM_DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2 and ≥ 2.
- LATENCY, 2, cycles from request acceptance to ack; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_req_mem_access  in  1  request valid; sampled only in StIdle
- in_addr  in  32  byte address
- in_data  in  32  write data, right-aligned for 8- and 16-bit accesses
- in_access_type  in  1  0 = DiatRead, 1 = DiatWrite
- in_access_size  in  2  0 = Dias32, 1 = Dias16, 2 = Dias8, 3 = DiasBad
- out_data  out  32  read data, zero-extended
- out_busy  out  1  high while a request is in flight
- out_ack  out  1  one-cycle completion pulse
- out_err  out  1  error flag for the acked request; valid only while out_ack = 1

Behaviour:
- Reset (async, rst = 1): state = StIdle; out_data, out_busy, out_ack, out_err = 0; latency counter = 0. RAM contents are not reset.
- FSM has three states: StIdle, StWait, StDone.
  - StIdle: if in_req_mem_access = 1, latch addr, data, type and size, then go to StWait (LATENCY ≥ 2, counter loaded with LATENCY−2) or StDone (LATENCY = 1).
  - StWait: decrement the counter; go to StDone when the counter reaches 0.
  - StDone: out_ack = 1, then return to StIdle.
- Timing: for a request accepted at clock edge N, out_ack is high in the cycle following edge N+LATENCY−1, i.e. exactly LATENCY cycles after acceptance.
- out_busy = 1 in StWait and StDone, and 0 in StIdle.
- The request line is ignored outside StIdle; there is no queueing. The CPU drops in_req_mem_access in the ack cycle. A request still held high in StIdle after an ack starts a new transaction.
- Error conditions (any one sets err):
  - size = DiasBad
  - size = Dias32 with addr[1:0] ≠ 0
  - size = Dias16 with addr[0] ≠ 0
  - addr[31 : log2(MEM_DEPTH_WORDS)+2] ≠ 0 (out of range)
- On error: no RAM write, out_data = 0, out_err = 1 with the ack.
- Word index is addr[log2(MEM_DEPTH_WORDS)+1 : 2]. Byte order is little-endian: byte lane k is bits [8k+7 : 8k].
- Writes commit at the StDone edge, with byte enables derived as follows:
  - Dias32: all four lanes.
  - Dias16: lanes {2·addr[1], 2·addr[1]+1}, taking in_data[15:0].
  - Dias8: lane addr[1:0], taking in_data[7:0].
- Writes leave out_data unchanged.
- Reads: out_data is updated in the ack cycle and holds until the next completed read (or errored request).
  - Dias16 returns the selected halfword in [15:0]; Dias8 returns the selected byte in [7:0]; upper bits are 0.
- Reset mid-transaction (StWait or StDone): the pending write is discarded, no ack is issued and the FSM returns to StIdle.

Decomposition:
- Package PkgFrost32MemResponder: the StIdle/StWait/StDone enum, and a lane-enable/alignment helper function.
- The access-type and access-size encodings come from the existing CPU package enums (DataInoutAccessType, DataInoutAccessSize).
- One sub-module: frost32_byte_lane_ram, a synchronous word RAM with a 4-bit byte-write-enable and combinational read.

Test Plan:
1. Write Dias32 0xDEADBEEF to 0x10, then read Dias32 from 0x10 (LATENCY = 2) → each ack exactly 2 cycles after accept; read returns 0xDEADBEEF with err = 0; out_busy high for 2 cycles per transaction.
2. After test 1, write Dias8 0xAA to 0x11 → read Dias32 from 0x10 returns 0xDEADAAEF; read Dias8 from 0x13 returns 0x000000DE; read Dias16 from 0x12 returns 0x0000DEAD.
3. Error cases:
   - Dias16 write to 0x11 → err = 1, out_data = 0, and a later read of 0x10 still returns 0xDEADAAEF.
   - DiasBad read → err = 1.
   - Dias32 read from 0x1000 (depth 1024) → err = 1.
4. Toggle in_req_mem_access with a different address while out_busy = 1 → ignored; exactly one ack, carrying the original transaction's data.
5. Assert rst during StWait of a Dias32 write of 0x12345678 to 0x20 → no ack, all outputs 0; a subsequent read of 0x20 returns the prior contents.
6. LATENCY = 1, back-to-back requests held high → ack every 2 cycles; out_busy = 1 only in the ack cycle; data correct.
